// File: rtl/combo_sender.sv
// Emulates a user keying a combination into a lock: each digit d becomes d presses
// of "next" followed by one "enter", every button phase paced by the slow tick.
module combo_sender #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        tick,
   input  logic                        start,
   input  logic                        abort,
   input  logic [DIGITS*DIGIT_W-1:0]   code,
   output logic                        next_btn,
   output logic                        enter_btn,
   output logic                        busy,
   output logic                        done
);

   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      NEXT_HI  = 3'd1,
      NEXT_LO  = 3'd2,
      ENTER_HI = 3'd3,
      ENTER_LO = 3'd4,
      FINISH   = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CODE_W-1:0]    code_q, code_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DIGIT_W-1:0]   cnt_q, cnt_d;
   logic                 next_btn_q, next_btn_d;
   logic                 enter_btn_q, enter_btn_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [CODE_W-1:0]    code_shift_s;

   assign code_shift_s = code_q << DIGIT_W;

   // Next-state logic; the digit in the top field of code_q is always the one being sent.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               code_d  = code;
               idx_d   = {IDX_W{1'b0}};
               cnt_d   = code[CODE_W-1 -: DIGIT_W];
               state_d = (code[CODE_W-1 -: DIGIT_W] != {DIGIT_W{1'b0}}) ? NEXT_HI : ENTER_HI;
            end else begin
               state_d = IDLE;
            end
         end
         NEXT_HI: begin
            if (tick) begin
               state_d = NEXT_LO;
            end else begin
               state_d = NEXT_HI;
            end
         end
         NEXT_LO: begin
            if (tick) begin
               cnt_d   = cnt_q - DIGIT_W'(1);
               state_d = (cnt_q != DIGIT_W'(1)) ? NEXT_HI : ENTER_HI;
            end else begin
               state_d = NEXT_LO;
            end
         end
         ENTER_HI: begin
            if (tick) begin
               state_d = ENTER_LO;
            end else begin
               state_d = ENTER_HI;
            end
         end
         ENTER_LO: begin
            if (!tick) begin
               state_d = ENTER_LO;
            end else if (idx_q == LAST_IDX) begin
               state_d = FINISH;
            end else begin
               code_d  = code_shift_s;
               idx_d   = idx_q + IDX_W'(1);
               cnt_d   = code_shift_s[CODE_W-1 -: DIGIT_W];
               state_d = (code_shift_s[CODE_W-1 -: DIGIT_W] != {DIGIT_W{1'b0}}) ? NEXT_HI : ENTER_HI;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over any tick-driven advance.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         idx_d   = {IDX_W{1'b0}};
         cnt_d   = {DIGIT_W{1'b0}};
      end else begin
         idx_d   = idx_d;
      end

      next_btn_d  = (state_d == NEXT_HI);
      enter_btn_d = (state_d == ENTER_HI);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == FINISH);
   end

   // State, sequencing registers and registered button/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         code_q      <= {CODE_W{1'b0}};
         idx_q       <= {IDX_W{1'b0}};
         cnt_q       <= {DIGIT_W{1'b0}};
         next_btn_q  <= 1'b0;
         enter_btn_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         next_btn_q  <= next_btn_d;
         enter_btn_q <= enter_btn_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign next_btn  = next_btn_q;
   assign enter_btn = enter_btn_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_combo_sender.sv
// Scoreboard bench for combo_sender: expected button events are derived from the code
// digits and compared against rising edges observed on the DUT outputs.
module tb_combo_sender;
   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 4;

   logic        clk = 1'b0;
   logic        rst_n, tick, start, abort;
   logic [15:0] code;
   logic        next_btn, enter_btn, busy, done;

   combo_sender #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
      .code(code), .next_btn(next_btn), .enter_btn(enter_btn), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int  vectors = 0;
   int  errors  = 0;
   byte exp_q[$];
   int  exp_cyc_q[$];
   int  per = 1;
   int  tcnt = 0;
   bit  aborting = 1'b0;
   int  n_seen = 0;
   bit  seq_done = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: digit d -> d 'N' presses then one 'E'; each press is two tick phases.
   task automatic push_expect(input logic [15:0] c);
      int phases = 0;
      for (int i = 0; i < DIGITS; i++) begin
         int d;
         d = int'((c >> (DIGIT_W * (DIGITS - 1 - i))) & 16'hF);
         repeat (d) exp_q.push_back("N");
         exp_q.push_back("E");
         phases += 2 * d + 2;
      end
      exp_q.push_back("D");
      exp_cyc_q.push_back(phases * per);
   endtask

   task automatic observe(input byte e);
      if (exp_q.size() == 0) check("unexpected_event", int'(e), 0);
      else check("event_order", int'(e), int'(exp_q.pop_front()));
   endtask

   // Monitor: samples on the falling edge, turns output edges into scoreboard events.
   initial begin
      logic pn, pe;
      int nlen, elen, bcnt;
      pn = 1'b0; pe = 1'b0; nlen = 0; elen = 0; bcnt = 0;
      forever begin
         @(negedge clk);
         check("exclusive_buttons", int'(next_btn & enter_btn), 0);
         if (next_btn && !pn) begin observe("N"); n_seen++; end
         if (enter_btn && !pe) observe("E");
         if (next_btn) nlen++;
         else begin
            if (pn && !aborting) check("next_width", nlen, per);
            nlen = 0;
         end
         if (enter_btn) elen++;
         else begin
            if (pe && !aborting) check("enter_width", elen, per);
            elen = 0;
         end
         if (done) begin
            observe("D");
            seq_done = 1'b1;
            if (exp_cyc_q.size() == 0) check("unexpected_done_cycles", bcnt, -1);
            else check("busy_cycles", bcnt, exp_cyc_q.pop_front());
         end
         if (busy && !done) bcnt++;
         else if (!busy) bcnt = 0;
         pn = next_btn;
         pe = enter_btn;
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      tcnt  = (tcnt + 1) % per;
      tick  = (tcnt == 0);
   endtask

   task automatic send(input logic [15:0] c);
      cyc();
      cyc();
      code     = c;
      start    = 1'b1;
      tcnt     = 0;
      tick     = 1'b1;
      aborting = 1'b0;
      n_seen   = 0;
      seq_done = 1'b0;
      push_expect(c);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!seq_done && n < 2000) begin cyc(); n++; end
      check("done_seen", int'(seq_done), 1);
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_quiet(input string name);
      check({name, "_next"}, int'(next_btn), 0);
      check({name, "_enter"}, int'(enter_btn), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_done"}, int'(done), 0);
   endtask

   initial begin
      int n;
      logic [15:0] rc;
      rst_n = 1'b0; tick = 1'b1; start = 1'b0; abort = 1'b0; code = 16'h0000;
      #1;
      check_quiet("reset");
      repeat (3) cyc();
      rst_n = 1'b1;

      per = 1; send(16'h3102); wait_done();
      per = 1; send(16'h0000); wait_done();
      per = 5; send(16'hF000); wait_done();

      // Restart attempt with a different code while busy must be ignored.
      per = 2; send(16'h2301);
      repeat (7) cyc();
      code = 16'h9999; start = 1'b1;
      cyc();
      code = 16'h5555;
      wait_done();

      // Abort during the second next pulse, then resend the full code.
      per = 3; send(16'h2413);
      n = 0;
      while (n_seen < 2 && n < 500) begin cyc(); n++; end
      check("second_next_seen", n_seen, 2);
      check("second_next_high", int'(next_btn), 1);
      aborting = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      check_quiet("abort");
      exp_q.delete(); exp_cyc_q.delete();
      repeat (10) cyc();
      check("no_done_after_abort", int'(seq_done), 0);
      send(16'h2413); wait_done();

      // Reset while enter is high.
      per = 2; send(16'h1000);
      n = 0;
      while (!enter_btn && n < 500) begin cyc(); n++; end
      check("enter_reached", int'(enter_btn), 1);
      aborting = 1'b1;
      rst_n = 1'b0;
      #1;
      check_quiet("async_reset");
      exp_q.delete(); exp_cyc_q.delete();
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (10) cyc();
      check("no_done_after_reset", int'(seq_done), 0);
      check("idle_after_reset", int'(busy), 0);

      // Start together with abort in IDLE does nothing.
      cyc();
      code = 16'h1111; start = 1'b1; abort = 1'b1;
      cyc();
      repeat (4) cyc();
      check("start_abort_idle", int'(busy), 0);

      for (int i = 0; i < 6; i++) begin
         per = $urandom_range(1, 3);
         rc  = 16'($urandom);
         send(rc);
         wait_done();
      end
      per = 1; send(16'hFFFF); wait_done();

      repeat (3) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
